csa_resolver: RTL

CSA_RESOLVER -- requirements
Module: csa_resolver

---
 rtl/csa_pkg.sv | 11 +
 rtl/cpa_chunk.sv | 16 +
 rtl/csa_resolver.sv | 97 +++++++++
 3 files changed

// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared defaults and state encoding for the carry-save resolver
package csa_pkg;
   localparam int CSA_WIDTH = 48;
   localparam int CSA_CHUNK = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/cpa_chunk.sv
// rtl/cpa_chunk.sv - combinational W-bit carry-propagate adder slice
module cpa_chunk #(
   parameter int W = 12
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout
);
   logic [W:0] total;

   assign total   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
   assign s       = total[W-1:0];
   assign cout    = total[W];
endmodule

// File: rtl/csa_resolver.sv
// rtl/csa_resolver.sv - resolves a carry-save pair into binary, one CHUNK per cycle LSB first
module csa_resolver
   import csa_pkg::*;
#(
   parameter int WIDTH = CSA_WIDTH,
   parameter int CHUNK = CSA_CHUNK
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] s_in,
   input  logic [WIDTH-1:0] c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   state_t           state;
   logic [WIDTH-1:0] s_reg;
   logic [WIDTH-1:0] c_reg;
   logic [CW-1:0]    k;
   logic             carry;
   logic [CHUNK-1:0] chunk_a;
   logic [CHUNK-1:0] chunk_b;
   logic [CHUNK-1:0] chunk_s;
   logic             chunk_cout;

   assign chunk_a = s_reg[int'(k)*CHUNK +: CHUNK];
   assign chunk_b = c_reg[int'(k)*CHUNK +: CHUNK];

   cpa_chunk #(.W(CHUNK)) u_chunk (
      .a    (chunk_a),
      .b    (chunk_b),
      .cin  (carry),
      .s    (chunk_s),
      .cout (chunk_cout)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         s_reg     <= '0;
         c_reg     <= '0;
         k         <= '0;
         carry     <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // in_ready comes up one edge after reset release, so gate capture on it
               if (in_valid && in_ready) begin
                  s_reg    <= s_in;
                  c_reg    <= c_in;
                  k        <= '0;
                  carry    <= 1'b0;
                  in_ready <= 1'b0;
                  state    <= ADD;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            ADD: begin
               sum[int'(k)*CHUNK +: CHUNK] <= chunk_s;
               carry <= chunk_cout;
               if (k == LAST) begin
                  carry_out <= chunk_cout;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  k <= k + 1'b1;
               end
            end
            DONE: begin
               // Consuming edge only returns to IDLE; acceptance waits for the next edge
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b0;
            end
         endcase
      end
   end
endmodule
